// File: rtl/aes_round_ctrl_if.sv
// ---------------------------------------------------------------------------
// aes_round_ctrl_if
//
// Purpose: bundles every non-clock/reset signal of aes_round_ctrl: the
// plaintext input handshake, the ciphertext output handshake, the round
// datapath link and the key store link.
//
// Handshake semantics (both directions): a transfer happens on a rising
// clock edge where valid and ready are both high. A producer that raises
// valid keeps it high and keeps its data stable until that edge. Ready may
// be high before valid, and the consumer may drop ready at any time.
//
// Signals:
//   iValid/oReady/iData        plaintext in (byte k at bits [8k+7:8k])
//   oValid/iReady/oData        ciphertext out (same byte order)
//   oRoundData/oFinal          state register and final-round flag to the
//                              combinational round datapath
//   iRoundData                 datapath result for oRoundData/oFinal
//   oKeyIdx/iRoundKey          round-key request and combinational answer
//   oBusy                      a block is in flight (ROUND or DONE)
//
// Modports:
//   master - the surrounding system (block source/sink, datapath, key store)
//   slave  - the round controller
// ---------------------------------------------------------------------------
interface aes_round_ctrl_if;
    logic         iValid;
    logic         oReady;
    logic [127:0] iData;
    logic         oValid;
    logic         iReady;
    logic [127:0] oData;
    logic [127:0] oRoundData;
    logic         oFinal;
    logic [127:0] iRoundData;
    logic [3:0]   oKeyIdx;
    logic [127:0] iRoundKey;
    logic         oBusy;

    modport master (
        output iValid, iData, iReady, iRoundData, iRoundKey,
        input  oReady, oValid, oData, oRoundData, oFinal, oKeyIdx, oBusy
    );

    modport slave (
        input  iValid, iData, iReady, iRoundData, iRoundKey,
        output oReady, oValid, oData, oRoundData, oFinal, oKeyIdx, oBusy
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes_round_ctrl
//
// Purpose: iterative AES encryption round sequencer. Accepts a plaintext
// block, applies the initial AddRoundKey, then steps an external
// combinational round datapath NR times, XORing in the round key from an
// external key store each cycle, and presents the ciphertext on an output
// handshake.
//
// Parameters:
//   NR         number of rounds: 10, 12 or 14 (AES-128/192/256)
//
// Ports:
//   iClk       clock, all state changes on the rising edge
//   iRst       asynchronous active-high reset
//   bus        aes_round_ctrl_if.slave (handshakes, datapath, key store)
//   oDbgState  current FSM state (0 IDLE, 1 ROUND, 2 DONE)
// ---------------------------------------------------------------------------
module aes_round_ctrl #(
    parameter int NR = 10
) (
    input  logic             iClk,
    input  logic             iRst,
    aes_round_ctrl_if.slave  bus,
    output logic [1:0]       oDbgState
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] LP_NR = 4'(NR);

    state_t       r_state;
    logic [127:0] r_st;
    logic [3:0]   r_rnd;
    logic [127:0] r_data;
    logic         r_valid;
    logic         r_ready;
    logic         r_final;
    logic         r_busy;

    logic [127:0] w_init_st;
    logic [127:0] w_next_st;
    logic         w_last;
    logic [3:0]   w_rnd_inc;

    assign w_init_st = bus.iData ^ bus.iRoundKey;
    assign w_next_st = bus.iRoundData ^ bus.iRoundKey;
    assign w_last    = (r_rnd == LP_NR);
    assign w_rnd_inc = r_rnd + 4'd1;

    // The round counter is zero outside ROUND, so it doubles as the key
    // index: key 0 is presented while idle for the initial AddRoundKey.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state <= ST_IDLE;
            r_st    <= '0;
            r_rnd   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_final <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.iValid) begin
                        r_st    <= w_init_st;
                        r_rnd   <= 4'd1;
                        r_final <= (LP_NR == 4'd1);
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    r_st <= w_next_st;
                    if (w_last) begin
                        // Final round result goes straight to the output
                        // register; the counter returns to 0 and stops.
                        r_data  <= w_next_st;
                        r_valid <= 1'b1;
                        r_rnd   <= '0;
                        r_final <= 1'b0;
                        r_state <= ST_DONE;
                    end else begin
                        r_rnd   <= w_rnd_inc;
                        r_final <= (w_rnd_inc == LP_NR);
                    end
                end
                ST_DONE: begin
                    if (bus.iReady) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.oReady     = r_ready;
    assign bus.oValid     = r_valid;
    assign bus.oData      = r_data;
    assign bus.oRoundData = r_st;
    assign bus.oFinal     = r_final;
    assign bus.oKeyIdx    = r_rnd;
    assign bus.oBusy      = r_busy;
    assign oDbgState      = r_state;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_round_ctrl
//
// Two controllers (NR=10 and NR=14) share clock and reset. The bench
// supplies the round datapath (SubBytes/ShiftRows/MixColumns) and the key
// store (expanded round keys) as combinational models, and checks the
// ciphertext against the FIPS-197 C.1 and C.3 vectors.
// ---------------------------------------------------------------------------
module tb_aes_round_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [127:0] exp_q[$];
    logic [127:0] rk10 [16];
    logic [127:0] rk14 [16];
    logic [127:0] pt_c1, ct_c1, ct_c3, pt_b, ct_b;
    logic [1:0]   dbg10, dbg14;

    aes_round_ctrl_if bus10 ();
    aes_round_ctrl_if bus14 ();

    aes_round_ctrl #(.NR(10)) u_dut10 (.iClk(clk), .iRst(rst), .bus(bus10), .oDbgState(dbg10));
    aes_round_ctrl #(.NR(14)) u_dut14 (.iClk(clk), .iRst(rst), .bus(bus14), .oDbgState(dbg14));

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- AES reference pieces ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from the GF(2^8) inverse (a^254) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv, base, e, s;
        inv = 8'h01; base = a; e = 8'hfe;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) inv = gmul(inv, base);
            base = gmul(base, base);
        end
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [127:0] bswap(input logic [127:0] v);
        logic [127:0] o;
        for (int k = 0; k < 16; k++) o[8*k +: 8] = v[8*(15-k) +: 8];
        return o;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic fin);
        logic [7:0]   b  [16];
        logic [7:0]   sr [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        o = '0;
        for (int k = 0; k < 16; k++) b[k] = sbox(s[8*k +: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[4*c+r] = b[4*((c+r)%4)+r];
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c]; a1 = sr[4*c+1]; a2 = sr[4*c+2]; a3 = sr[4*c+3];
            if (fin) begin
                o[32*c +: 32] = {a3, a2, a1, a0};
            end else begin
                o[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
                o[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
                o[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
                o[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
            end
        end
        return o;
    endfunction

    task automatic expand_key(input logic [255:0] key, input int nk, input bit to14);
        logic [7:0] w [240];
        logic [7:0] t [4];
        logic [7:0] tmp, rcon;
        int nr, nw;
        nr = nk + 6;
        nw = 4 * (nr + 1);
        rcon = 8'h01;
        for (int i = 0; i < 4*nk; i++) w[i] = key[8*i +: 8];
        for (int i = nk; i < nw; i++) begin
            for (int j = 0; j < 4; j++) t[j] = w[4*(i-1)+j];
            if (i % nk == 0) begin
                tmp  = t[0];
                t[0] = sbox(t[1]) ^ rcon;
                t[1] = sbox(t[2]);
                t[2] = sbox(t[3]);
                t[3] = sbox(tmp);
                rcon = xtime(rcon);
            end else if (nk > 6 && i % nk == 4) begin
                for (int j = 0; j < 4; j++) t[j] = sbox(t[j]);
            end
            for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-nk)+j] ^ t[j];
        end
        for (int r = 0; r <= nr; r++)
            for (int k = 0; k < 16; k++)
                if (to14) rk14[r][8*k +: 8] = w[16*r+k];
                else      rk10[r][8*k +: 8] = w[16*r+k];
    endtask

    function automatic logic [127:0] aes_encrypt10(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rk10[0];
        for (int r = 1; r <= 10; r++) s = aes_round(s, r == 10) ^ rk10[r];
        return s;
    endfunction

    // datapath and key store models
    assign bus10.iRoundData = aes_round(bus10.oRoundData, bus10.oFinal);
    assign bus10.iRoundKey  = rk10[bus10.oKeyIdx];
    assign bus14.iRoundData = aes_round(bus14.oRoundData, bus14.oFinal);
    assign bus14.iRoundKey  = rk14[bus14.oKeyIdx];

    // ---------------- scoreboard (NR=10 output handshakes) ----------------
    always @(negedge clk) begin
        if (!rst && bus10.oValid && bus10.iReady) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: oData=%h delivered with no block expected", bus10.oData);
            end else if (bus10.oData !== exp_q[0]) begin
                n_fail++;
                $display("FAIL sb_data: oData=%h expected %h", bus10.oData, exp_q[0]);
                void'(exp_q.pop_front());
            end else begin
                void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d blocks outstanding, expected 0", name, exp_q.size());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({bus10.oReady, bus10.oValid, bus10.oBusy, bus10.oFinal, bus10.oKeyIdx, dbg10} !== {4'b1000, 4'd0, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_ctrl: rdy/vld/busy/fin=%b%b%b%b key=%0d st=%0d, expected 1000 0 0",
                     bus10.oReady, bus10.oValid, bus10.oBusy, bus10.oFinal, bus10.oKeyIdx, dbg10);
        end
        n_checks++;
        if ({bus10.oData, bus10.oRoundData} !== 256'd0) begin
            n_fail++;
            $display("FAIL reset_data: oData=%h oRoundData=%h, expected 0", bus10.oData, bus10.oRoundData);
        end
        n_checks++;
        if ({bus14.oReady, bus14.oValid, bus14.oBusy} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_nr14: rdy/vld/busy=%b, expected 100", {bus14.oReady, bus14.oValid, bus14.oBusy});
        end
        rst = 1'b0;
    endtask

    task automatic test_fips128();
        int  seen;
        bus10.iReady = 1'b1;
        after_edge();
        bus10.iValid = 1'b1;
        bus10.iData  = pt_c1;
        @(negedge clk);
        n_checks++;
        if ({bus10.oReady, bus10.oKeyIdx} !== {1'b1, 4'd0}) begin
            n_fail++;
            $display("FAIL c1_idle: oReady=%b oKeyIdx=%0d, expected 1 0", bus10.oReady, bus10.oKeyIdx);
        end
        exp_q.push_back(ct_c1);
        after_edge();
        bus10.iValid = 1'b0;
        seen = 0;
        for (int k = 1; k <= 30 && seen == 0; k++) begin
            @(negedge clk);
            if (bus10.oValid) begin
                seen = k;
            end else begin
                n_checks++;
                if ({bus10.oFinal, bus10.oKeyIdx} !== {k == 10, 4'(k)}) begin
                    n_fail++;
                    $display("FAIL c1_keyseq: cycle %0d oFinal=%b oKeyIdx=%0d, expected %b %0d",
                             k, bus10.oFinal, bus10.oKeyIdx, k == 10, k);
                end
            end
        end
        n_checks++;
        if (seen - 1 != 10) begin
            n_fail++;
            $display("FAIL c1_latency: oValid after %0d edges, expected 10", seen - 1);
        end
        n_checks++;
        if (bus10.oData !== ct_c1) begin
            n_fail++;
            $display("FAIL c1_cipher: oData=%h expected %h", bus10.oData, ct_c1);
        end
        n_checks++;
        if ({bus10.oBusy, bus10.oFinal, bus10.oKeyIdx, dbg10} !== {2'b10, 4'd0, 2'd2}) begin
            n_fail++;
            $display("FAIL c1_done: busy=%b fin=%b key=%0d st=%0d, expected 1 0 0 2",
                     bus10.oBusy, bus10.oFinal, bus10.oKeyIdx, dbg10);
        end
        @(negedge clk);
        n_checks++;
        if ({bus10.oValid, bus10.oReady, bus10.oBusy} !== 3'b010) begin
            n_fail++;
            $display("FAIL c1_onecycle: vld/rdy/busy=%b, expected 010", {bus10.oValid, bus10.oReady, bus10.oBusy});
        end
    endtask

    task automatic test_backpressure();
        int seen;
        bus10.iReady = 1'b0;
        after_edge();
        bus10.iValid = 1'b1;
        bus10.iData  = pt_c1;
        exp_q.push_back(ct_c1);
        after_edge();
        bus10.iValid = 1'b0;
        seen = 0;
        for (int i = 0; i < 30 && seen == 0; i++) begin
            @(negedge clk);
            if (bus10.oValid) seen = 1;
        end
        n_checks++;
        if (seen == 0) begin
            n_fail++;
            $display("FAIL bp_timeout: oValid=0 after 30 cycles, expected 1");
        end
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if ({bus10.oValid, bus10.oData} !== {1'b1, ct_c1}) begin
                n_fail++;
                $display("FAIL bp_hold: cycle %0d oValid=%b oData=%h, expected 1 %h", i, bus10.oValid, bus10.oData, ct_c1);
            end
        end
        after_edge();
        bus10.iReady = 1'b1;
        @(negedge clk);
        after_edge();
        @(negedge clk);
        n_checks++;
        if ({bus10.oValid, bus10.oReady, bus10.oData} !== {2'b01, ct_c1}) begin
            n_fail++;
            $display("FAIL bp_release: oValid=%b oReady=%b oData=%h, expected 0 1 %h",
                     bus10.oValid, bus10.oReady, bus10.oData, ct_c1);
        end
    endtask

    task automatic test_back_to_back();
        int n_acc;
        int acc [2];
        n_acc = 0;
        acc[0] = 0; acc[1] = 0;
        bus10.iReady = 1'b1;
        after_edge();
        bus10.iValid = 1'b1;
        bus10.iData  = pt_c1;
        for (int e = 0; e < 60 && n_acc < 2; e++) begin
            @(negedge clk);
            if (bus10.oReady) begin
                acc[n_acc] = e;
                exp_q.push_back(n_acc == 0 ? ct_c1 : ct_b);
                n_acc++;
            end
            after_edge();
            // the next block is presented while the first is still in flight
            if (n_acc == 1) bus10.iData = pt_b;
        end
        bus10.iValid = 1'b0;
        n_checks++;
        if (n_acc != 2 || acc[1] - acc[0] != 12) begin
            n_fail++;
            $display("FAIL b2b_spacing: %0d accepts %0d cycles apart, expected 2 accepts 12 apart",
                     n_acc, acc[1] - acc[0]);
        end
        drain("b2b");
    endtask

    task automatic test_reset_mid_round();
        int seen;
        int vld_seen;
        bus10.iReady = 1'b1;
        after_edge();
        bus10.iValid = 1'b1;
        bus10.iData  = pt_c1;
        after_edge();
        bus10.iValid = 1'b0;
        seen = 0;
        for (int i = 0; i < 30 && seen == 0; i++) begin
            @(negedge clk);
            if (bus10.oKeyIdx == 4'd5) seen = 1;
        end
        n_checks++;
        if (seen == 0) begin
            n_fail++;
            $display("FAIL rst_mid_reach: oKeyIdx never reached 5");
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus10.oReady, bus10.oValid, bus10.oBusy, bus10.oFinal, bus10.oKeyIdx, dbg10} !== {4'b1000, 4'd0, 2'd0}) begin
            n_fail++;
            $display("FAIL rst_mid_ctrl: rdy/vld/busy/fin=%b%b%b%b key=%0d st=%0d, expected 1000 0 0",
                     bus10.oReady, bus10.oValid, bus10.oBusy, bus10.oFinal, bus10.oKeyIdx, dbg10);
        end
        n_checks++;
        if ({bus10.oData, bus10.oRoundData} !== 256'd0) begin
            n_fail++;
            $display("FAIL rst_mid_data: oData=%h oRoundData=%h, expected 0", bus10.oData, bus10.oRoundData);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        vld_seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus10.oValid || bus10.oBusy) vld_seen = 1;
        end
        n_checks++;
        if (vld_seen != 0) begin
            n_fail++;
            $display("FAIL rst_mid_novalid: oValid/oBusy seen=%0d after reset, expected 0", vld_seen);
        end
        after_edge();
        bus10.iValid = 1'b1;
        bus10.iData  = pt_c1;
        exp_q.push_back(ct_c1);
        after_edge();
        bus10.iValid = 1'b0;
        drain("rst_mid");
    endtask

    task automatic test_reset_release_valid();
        after_edge();
        rst = 1'b1;
        bus10.iReady = 1'b1;
        bus10.iValid = 1'b1;
        bus10.iData  = pt_c1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({bus10.oBusy, bus10.oReady} !== 2'b01) begin
            n_fail++;
            $display("FAIL rel_in_reset: busy/rdy=%b, expected 01", {bus10.oBusy, bus10.oReady});
        end
        rst = 1'b0;
        exp_q.push_back(ct_c1);
        after_edge();
        bus10.iValid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus10.oBusy, bus10.oKeyIdx} !== {1'b1, 4'd1}) begin
            n_fail++;
            $display("FAIL rel_accept: busy=%b key=%0d, expected 1 1", bus10.oBusy, bus10.oKeyIdx);
        end
        drain("rel");
    endtask

    task automatic test_nr14();
        int seen;
        int max_key;
        bus14.iReady = 1'b1;
        after_edge();
        bus14.iValid = 1'b1;
        bus14.iData  = pt_c1;
        after_edge();
        bus14.iValid = 1'b0;
        seen = 0;
        max_key = 0;
        for (int k = 1; k <= 40 && seen == 0; k++) begin
            @(negedge clk);
            if (bus14.oValid) seen = k;
            else if (int'(bus14.oKeyIdx) > max_key) max_key = int'(bus14.oKeyIdx);
        end
        n_checks++;
        if (seen - 1 != 14) begin
            n_fail++;
            $display("FAIL c3_latency: oValid after %0d edges, expected 14", seen - 1);
        end
        n_checks++;
        if (max_key != 14) begin
            n_fail++;
            $display("FAIL c3_keymax: max oKeyIdx=%0d, expected 14", max_key);
        end
        n_checks++;
        if ({bus14.oData, dbg14} !== {ct_c3, 2'd2}) begin
            n_fail++;
            $display("FAIL c3_cipher: oData=%h st=%0d, expected %h 2", bus14.oData, dbg14, ct_c3);
        end
        @(negedge clk);
        n_checks++;
        if ({bus14.oValid, bus14.oReady} !== 2'b01) begin
            n_fail++;
            $display("FAIL c3_release: vld/rdy=%b, expected 01", {bus14.oValid, bus14.oReady});
        end
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        logic [255:0] key;
        rst = 1'b1;
        bus10.iValid = 1'b0; bus10.iReady = 1'b0; bus10.iData = '0;
        bus14.iValid = 1'b0; bus14.iReady = 1'b0; bus14.iData = '0;
        for (int k = 0; k < 16; k++) begin
            rk10[k] = '0;
            rk14[k] = '0;
        end
        key = '0;
        for (int k = 0; k < 32; k++) key[8*k +: 8] = 8'(k);
        expand_key(key, 4, 1'b0);
        expand_key(key, 8, 1'b1);
        pt_c1 = bswap(128'h00112233445566778899aabbccddeeff);
        ct_c1 = bswap(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        ct_c3 = bswap(128'h8ea2b7ca516745bfeafc49904b496089);
        pt_b  = bswap(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0);
        ct_b  = aes_encrypt10(pt_b);

        test_reset();
        test_fips128();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_round();
        test_reset_release_valid();
        test_nr14();

        repeat (3) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL final_queue: %0d blocks outstanding, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
